// File: rtl/mips_trace_monitor.sv
// mips_trace_monitor
//
// Watches the commit stream of a small MIPS-like core between a start pulse
// and the first commit at or beyond an end-of-program PC. Every recorded
// commit is pushed into a first-word-fall-through trace FIFO and counted in
// a per-opcode histogram plus a total. Counters saturate instead of wrapping.
//
// Ports:
//   clock          single clock, rising-edge
//   reset_n        asynchronous active-low reset
//   start          arm / re-arm (accepted only in IDLE or DONE)
//   pc_limit       end-of-program PC, latched on an accepted start
//   commit_valid   one instruction retires this cycle
//   commit_pc      PC of the retiring instruction
//   commit_instr   retiring instruction (opcode in the top 4 bits)
//   commit_result  result of the retiring instruction
//   rd_en          pop the FIFO head
//   rd_valid       FIFO not empty
//   rd_data        FIFO head as {pc, instr, result}
//   cnt_sel        opcode whose retire count is shown on cnt_value
//   cnt_value      retire count for cnt_sel
//   total_count    total recorded commits
//   overflow       sticky: a trace entry was dropped because the FIFO was full
//   busy           controller in RUN or DRAIN
//   done           controller in DONE
//
// Read handshake: rd_data is meaningful whenever rd_valid is 1; an entry is
// consumed on a rising edge where rd_valid and rd_en are both 1. rd_en while
// rd_valid is 0 has no effect. There is no back-pressure on the commit side:
// a commit that cannot be stored is dropped and flagged through overflow.

module mips_trace_monitor #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 16,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [PC_W-1:0]             pc_limit,
    input  logic                        commit_valid,
    input  logic [PC_W-1:0]             commit_pc,
    input  logic [INSTR_W-1:0]          commit_instr,
    input  logic [DATA_W-1:0]           commit_result,
    input  logic                        rd_en,
    output logic                        rd_valid,
    output logic [PC_W+INSTR_W+DATA_W-1:0] rd_data,
    input  logic [3:0]                  cnt_sel,
    output logic [CNT_W-1:0]            cnt_value,
    output logic [CNT_W-1:0]            total_count,
    output logic                        overflow,
    output logic                        busy,
    output logic                        done
);

    localparam int ENTRY_W = PC_W + INSTR_W + DATA_W;
    localparam int AW      = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_W-1:0]    limit_q;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [AW:0]        wr_next;
    logic [AW:0]        rd_next;
    logic [ENTRY_W-1:0] head_q;
    logic [ENTRY_W-1:0] head_next;
    logic               valid_q;
    logic               valid_next;

    logic [CNT_W-1:0]   op_cnt [16];
    logic [CNT_W-1:0]   total_q;
    logic               overflow_q;

    logic               arm;
    logic               in_run;
    logic               commit_end;
    logic               record;
    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [3:0]         opcode;
    logic [ENTRY_W-1:0] entry_in;

    // ------------------------------------------------------------------
    // Commit classification
    // ------------------------------------------------------------------
    assign arm        = start && (state == S_IDLE || state == S_DONE);
    assign in_run     = (state == S_RUN);
    assign commit_end = in_run && commit_valid && (commit_pc >= limit_q);
    assign record     = in_run && commit_valid && (commit_pc <  limit_q);
    assign opcode     = commit_instr[INSTR_W-1 -: 4];
    assign entry_in   = {commit_pc, commit_instr, commit_result};

    // ------------------------------------------------------------------
    // FIFO status; the extra pointer bit separates full from empty
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop  = rd_en && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = record && (!fifo_full || pop);
    assign drop = record && fifo_full && !pop;

    // Next head is computed ahead of the edge so rd_data/rd_valid can be
    // plain registers while keeping zero read latency after a push.
    always_comb begin
        wr_next    = wr_ptr + (AW+1)'(push);
        rd_next    = rd_ptr + (AW+1)'(pop);
        valid_next = (wr_next != rd_next);
        head_next  = '0;
        if (valid_next) begin
            // The new head is the slot being written this edge when the
            // FIFO was empty, or held one entry that is popped now.
            if (push && (rd_next == wr_ptr)) begin
                head_next = entry_in;
            end else begin
                head_next = mem[rd_next[AW-1:0]];
            end
        end
    end

    // Storage array carries no reset; only pointers define its contents.
    always_ff @(posedge clock) begin
        if (push && !arm) begin
            mem[wr_ptr[AW-1:0]] <= entry_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else if (arm) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            head_q  <= head_next;
            valid_q <= valid_next;
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = head_q;

    // ------------------------------------------------------------------
    // Counters, end-of-program limit and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                op_cnt[i] <= '0;
            end
            total_q    <= '0;
            overflow_q <= 1'b0;
            limit_q    <= '0;
        end else if (arm) begin
            for (int i = 0; i < 16; i++) begin
                op_cnt[i] <= '0;
            end
            total_q    <= '0;
            overflow_q <= 1'b0;
            limit_q    <= pc_limit;
        end else begin
            // Counts are kept even when the trace entry itself is dropped.
            if (record) begin
                if (op_cnt[opcode] != {CNT_W{1'b1}}) begin
                    op_cnt[opcode] <= op_cnt[opcode] + CNT_W'(1);
                end
                if (total_q != {CNT_W{1'b1}}) begin
                    total_q <= total_q + CNT_W'(1);
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign cnt_value   = op_cnt[cnt_sel];
    assign total_count = total_q;
    assign overflow    = overflow_q;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start)      state_next = S_RUN;
            S_RUN:   if (commit_end) state_next = S_DRAIN;
            S_DRAIN: if (fifo_empty) state_next = S_DONE;
            S_DONE:  if (start)      state_next = S_RUN;
            default:                 state_next = S_IDLE;
        endcase
    end

    assign busy = (state == S_RUN) || (state == S_DRAIN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Testbench for mips_trace_monitor. A default-parameter instance carries the
// trace and histogram checks; a second instance with 4-bit counters shares
// the same stimulus and is inspected only for saturation.

module tb_mips_trace_monitor;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 16;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 16;
  localparam int CNT_W   = 16;
  localparam int ENT_W   = PC_W + INSTR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #50 clock = ~clock;

  logic               start = 1'b0;
  logic [PC_W-1:0]    pc_limit = '0;
  logic               commit_valid = 1'b0;
  logic [PC_W-1:0]    commit_pc = '0;
  logic [INSTR_W-1:0] commit_instr = '0;
  logic [DATA_W-1:0]  commit_result = '0;
  logic               rd_en = 1'b0;
  logic [3:0]         cnt_sel = '0;

  logic               rd_valid;
  logic [ENT_W-1:0]   rd_data;
  logic [CNT_W-1:0]   cnt_value;
  logic [CNT_W-1:0]   total_count;
  logic               overflow;
  logic               busy;
  logic               done;

  logic               s_rd_valid;
  logic [ENT_W-1:0]   s_rd_data;
  logic [3:0]         s_cnt_value;
  logic [3:0]         s_total_count;
  logic               s_overflow;
  logic               s_busy;
  logic               s_done;

  mips_trace_monitor #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pc_limit(pc_limit),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_result(commit_result), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .cnt_sel(cnt_sel), .cnt_value(cnt_value), .total_count(total_count),
    .overflow(overflow), .busy(busy), .done(done)
  );

  mips_trace_monitor #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(4)
  ) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .pc_limit(pc_limit),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_result(commit_result), .rd_en(rd_en), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .cnt_sel(cnt_sel), .cnt_value(s_cnt_value), .total_count(s_total_count),
    .overflow(s_overflow), .busy(s_busy), .done(s_done)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [ENT_W-1:0] exp_q[$];
  int exp_hist[16];
  int exp_total;
  bit exp_ovf;

  task automatic check(input string tag, input logic [ENT_W-1:0] got, input logic [ENT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic arm(input logic [PC_W-1:0] limit);
    start = 1'b1;
    pc_limit = limit;
    tick();
    start = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_hist[i] = 0;
    exp_total = 0;
    exp_ovf = 1'b0;
  endtask

  task automatic commit(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr, input bit rec);
    logic [DATA_W-1:0] res;
    res = $urandom;
    commit_valid = 1'b1;
    commit_pc = pc;
    commit_instr = instr;
    commit_result = res;
    tick();
    commit_valid = 1'b0;
    if (rec) begin
      exp_total++;
      exp_hist[instr[INSTR_W-1 -: 4]]++;
      if (exp_q.size() < DEPTH) exp_q.push_back({pc, instr, res});
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic pop_one(input string tag);
    logic [ENT_W-1:0] front;
    front = exp_q.pop_front();
    check({tag, "_valid"}, rd_valid, 1'b1);
    check(tag, rd_data, front);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_one(tag);
  endtask

  // Commit and pop on the same edge; the bench pops its model first so the
  // new entry always finds room.
  task automatic commit_pop(input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] instr);
    logic [ENT_W-1:0] front;
    logic [DATA_W-1:0] res;
    res = $urandom;
    front = exp_q.pop_front();
    check("cp_head", rd_data, front);
    commit_valid = 1'b1;
    commit_pc = pc;
    commit_instr = instr;
    commit_result = res;
    rd_en = 1'b1;
    tick();
    commit_valid = 1'b0;
    rd_en = 1'b0;
    exp_total++;
    exp_hist[instr[INSTR_W-1 -: 4]]++;
    exp_q.push_back({pc, instr, res});
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_total"}, total_count, exp_total);
    for (int i = 0; i < 16; i++) begin
      cnt_sel = 4'(i);
      #1;
      check($sformatf("%s_cnt%0d", tag, i), cnt_value, exp_hist[i]);
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [3:0] op);
    logic [11:0] low;
    low = 12'($urandom);
    return {op, low};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) exp_hist[i] = 0;
    exp_total = 0;
    exp_ovf = 1'b0;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", rd_valid, 1'b0);
    check("rst_data", rd_data, '0);
    check("rst_total", total_count, '0);
    check("rst_cnt", cnt_value, '0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    repeat (2) @(posedge clock);
    #10 reset_n = 1'b1;
    tick();
    check("idle_busy", busy, 1'b0);

    // Basic trace: 15 recorded commits then the end-of-program commit
    arm(32'd30);
    check("t1_busy_run", busy, 1'b1);
    for (int i = 0; i < 15; i++) commit(32'(2 * i), mk_instr(4'($urandom_range(0, 15))), 1'b1);
    commit(32'd30, mk_instr(4'd3), 1'b0);
    check("t1_total", total_count, 15);
    check("t1_busy_drain", busy, 1'b1);
    check("t1_done_early", done, 1'b0);
    drain("t1_pop");
    check("t1_empty", rd_valid, 1'b0);
    check("t1_busy_last", busy, 1'b1);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_busy_off", busy, 1'b0);
    commit(32'd4, mk_instr(4'd1), 1'b0);
    check_counts("t1");

    // Histogram, start ignored in RUN, pops while running
    arm(32'd100);
    commit(32'd0,  mk_instr(4'd0),  1'b1);
    commit(32'd4,  mk_instr(4'd4),  1'b1);
    commit(32'd8,  mk_instr(4'd0),  1'b1);
    commit(32'd12, mk_instr(4'd15), 1'b1);
    commit(32'd16, mk_instr(4'd4),  1'b1);
    commit(32'd20, mk_instr(4'd4),  1'b1);
    check_counts("t2");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_start_ign", total_count, 6);
    pop_one("t2_pop_run");
    pop_one("t2_pop_run");
    commit(32'd200, mk_instr(4'd2), 1'b0);
    drain("t2_pop");
    wait_done("t2", 10);

    // Overflow, rd_en on empty FIFO
    arm(32'd1000);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_empty_pop", rd_valid, 1'b0);
    for (int i = 0; i < 17; i++) commit(32'(2 * i), mk_instr(4'($urandom_range(0, 15))), 1'b1);
    check("t3_ovf", overflow, exp_ovf);
    check("t3_total", total_count, 17);
    check("t3_sat_total", s_total_count, 15);
    drain("t3_pop");
    check("t3_empty", rd_valid, 1'b0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("t3_empty_pop2", rd_valid, 1'b0);
    check("t3_ovf_sticky", overflow, 1'b1);
    commit(32'd5000, mk_instr(4'd0), 1'b0);
    wait_done("t3", 10);

    // Full FIFO with simultaneous commit and pop
    arm(32'd1000);
    check("t4_ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 16; i++) commit(32'(4 * i), mk_instr(4'($urandom_range(0, 15))), 1'b1);
    commit_pop(32'd100, mk_instr(4'd9));
    check("t4_ovf", overflow, 1'b0);
    check("t4_total", total_count, 17);
    drain("t4_pop");
    check("t4_empty", rd_valid, 1'b0);
    commit(32'd2000, mk_instr(4'd0), 1'b0);
    wait_done("t4", 10);

    // Saturation on the 4-bit counter instance
    arm(32'd1000);
    for (int i = 0; i < 20; i++) commit(32'(2 * i), mk_instr(4'd2), 1'b1);
    cnt_sel = 4'd2;
    #1;
    check("t5_sat_cnt", s_cnt_value, 4'd15);
    check("t5_sat_total", s_total_count, 4'd15);
    check("t5_cnt", cnt_value, 20);
    check("t5_ovf", overflow, exp_ovf);
    drain("t5_pop");
    commit(32'd3000, mk_instr(4'd0), 1'b0);
    wait_done("t5", 10);

    // Reset in the middle of RUN
    arm(32'd1000);
    for (int i = 0; i < 5; i++) commit(32'(2 * i), mk_instr(4'd2), 1'b1);
    cnt_sel = 4'd2;
    #10 reset_n = 1'b0;
    #1;
    check("t6_valid", rd_valid, 1'b0);
    check("t6_data", rd_data, '0);
    check("t6_total", total_count, '0);
    check("t6_cnt", cnt_value, '0);
    check("t6_ovf", overflow, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    #10 reset_n = 1'b1;
    tick();
    check("t6_idle", busy, 1'b0);
    arm(32'd50);
    check("t6_total_new", total_count, '0);
    check("t6_busy_new", busy, 1'b1);
    check("t6_valid_new", rd_valid, 1'b0);
    commit(32'd2, mk_instr(4'd7), 1'b1);
    check("t6_total_one", total_count, 1);
    drain("t6_pop");
    commit(32'd60, mk_instr(4'd0), 1'b0);
    wait_done("t6", 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mips_trace_monitor.md
MIPS_TRACE_MONITOR -- requirements
Module: mips_trace_monitor

Interface
REQ-001 The block SHALL have these parameters:
- PC_W, 32: commit PC width.
- INSTR_W, 16: instruction width; opcode is bits [INSTR_W-1:INSTR_W-4].
- DATA_W, 32: result width.
- DEPTH, 16: trace FIFO entries, power of two, at least 2.
- CNT_W, 16: counter width.

REQ-002 The block SHALL have these ports, clock and reset first:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  arm or re-arm the monitor.
- pc_limit  in  PC_W  first PC treated as end of program; sampled on the start cycle.
- commit_valid  in  1  one instruction retires this cycle.
- commit_pc  in  PC_W  PC of the retiring instruction.
- commit_instr  in  INSTR_W  retiring instruction.
- commit_result  in  DATA_W  ALU/load result of the retiring instruction.
- rd_en  in  1  pop the trace FIFO head.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  PC_W+INSTR_W+DATA_W  FIFO head as {pc, instr, result}.
- cnt_sel  in  4  opcode whose retire count is read.
- cnt_value  out  CNT_W  retire count for opcode cnt_sel.
- total_count  out  CNT_W  total retired instructions recorded.
- overflow  out  1  sticky: at least one trace entry was dropped.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.

Function
REQ-003 The controller SHALL have four states, IDLE, RUN, DRAIN and DONE, with these transitions:
- IDLE to RUN on start.
- RUN to DRAIN on a commit with commit_pc >= pc_limit (unsigned compare).
- DRAIN to DONE when the FIFO is empty.
- DONE to RUN on start.
REQ-004 A start accepted in IDLE or DONE SHALL do all of the following in the same edge:
- clear all 16 opcode counters, total_count, overflow and the FIFO pointers;
- latch pc_limit.
REQ-005 start SHALL be ignored in RUN and DRAIN.
REQ-006 A commit in RUN with commit_pc < pc_limit SHALL be recorded:
- push {commit_pc, commit_instr, commit_result} into the FIFO;
- increment the counter indexed by the opcode;
- increment total_count.
REQ-007 The end-of-program commit (commit_pc >= pc_limit) SHALL NOT be recorded.
REQ-008 Commits in IDLE, DRAIN or DONE SHALL be ignored.
REQ-009 All counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-010 The FIFO SHALL be first-word-fall-through: rd_data and rd_valid come from registers, with zero-cycle read latency after a push.
REQ-011 rd_en with the FIFO empty SHALL be ignored, with pointers unchanged.
REQ-012 The FIFO SHALL be popped by rd_en in any state.
REQ-013 A push while full with no simultaneous pop SHALL be dropped, set overflow, and still update the counters.
REQ-014 A push and pop in the same cycle SHALL both succeed whether full or not, leaving occupancy unchanged.
REQ-015 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by one extra pointer bit.
REQ-016 cnt_value SHALL be combinational from cnt_sel and reflect counter state after the last edge.
REQ-017 busy and done SHALL be decoded from state registers only.

Reset
REQ-018 reset_n low SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- FIFO empty (rd_valid 0);
- rd_data 0;
- all counters, total_count and cnt_value 0;
- overflow 0, busy 0, done 0.
REQ-019 Reset asserted mid-RUN or mid-DRAIN SHALL discard all trace and counts.
REQ-020 After reset_n rises, the first accepted start SHALL be on the first rising edge with start high.

Verification
REQ-021 Basic trace: start with pc_limit=30, then 15 commits at PC 0,2,...,28, then a commit at PC 30 -> total_count=15; busy=1 until the FIFO is drained; after 15 pops, done=1 the next cycle.
REQ-022 Histogram: record 2 commits with opcode 0000, 3 with 0100 and 1 with 1111 -> cnt_sel=0 reads 2, cnt_sel=4 reads 3, cnt_sel=15 reads 1, and all other opcodes read 0.
REQ-023 Overflow: DEPTH=16 with 17 commits and no pops -> overflow=1; 16 entries pop in order with PCs of the first 16 commits; total_count=17.
REQ-024 Full plus simultaneous pop: FIFO full, then commit and rd_en in the same cycle -> overflow stays 0, occupancy stays 16, and the new entry appears as the last entry.
REQ-025 Edge cases:
- Saturation with CNT_W=4: 20 commits of opcode 0010 -> cnt_value=15.
- rd_en on an empty FIFO -> no change.
REQ-026 Reset mid-RUN: after 5 commits, pull reset_n low between clock edges -> all outputs 0 immediately; the next start gives total_count=0.
